// File: rtl/encoder_pkg.sv
// Shared definitions for the RV64 instruction encoder: format codes, base
// opcodes and instruction field positions.
package encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_RSV6 = 3'd6,
        FMT_RSV7 = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    function automatic logic fmt_reserved(input logic [2:0] fmt);
        return (fmt > 3'd5);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters a 64-bit immediate into its 32-bit instruction bit positions and
// flags unencodable immediates when IMM_RANGE_CHECK_EN is defined.
module imm_pack
    import encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [63:0] imm,
    output logic [31:0] imm_bits,
    output logic        imm_bad
);

    always_comb begin
        imm_bits = '0;
        case (fmt_e'(fmt))
            FMT_I: imm_bits[31:20] = imm[11:0];
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
            end
            FMT_U: imm_bits[31:12] = imm[31:12];
            FMT_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
            end
            default: imm_bits = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits N signed bits when everything above bit N-2 matches the sign bit.
    logic fits12, fits13, fits21, fits32;
    assign fits12 = (imm[63:11] == {53{imm[11]}});
    assign fits13 = (imm[63:12] == {52{imm[12]}});
    assign fits21 = (imm[63:20] == {44{imm[20]}});
    assign fits32 = (imm[63:31] == {33{imm[31]}});

    always_comb begin
        imm_bad = 1'b0;
        case (fmt_e'(fmt))
            FMT_I, FMT_S: imm_bad = !fits12;
            FMT_B:        imm_bad = !fits13 || imm[0];
            FMT_J:        imm_bad = !fits21 || imm[0];
            FMT_U:        imm_bad = (imm[11:0] != 12'd0) || !fits32;
            default:      imm_bad = 1'b0;
        endcase
    end
`else
    logic unused_imm;
    assign unused_imm = ^{imm[63:32], imm[0]};
    assign imm_bad    = 1'b0;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage valid/ready RV64 instruction packer with a count of delivered
// words. Define IMM_RANGE_CHECK_EN to flag unencodable immediates on out_err.
module instruction_encoder
    import encoder_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [2:0]         in_funct3,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [6:0]         in_funct7,
    input  logic [63:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_err,
    output logic [COUNT_W-1:0] enc_count
);

    logic        rdy_q;
    logic        s1_valid, s2_valid;
    logic        s1_advance, in_fire;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_opcode, s1_funct7;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [2:0]  s1_funct3;
    logic [63:0] s1_imm;
    logic [31:0] imm_bits, packed_word;
    logic        imm_bad, packed_err;

    // rdy_q keeps the input closed for the first cycle after reset release.
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = rdy_q && (!s1_valid || s1_advance);
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = s2_valid;

    imm_pack u_imm_pack (
        .fmt      (s1_fmt),
        .imm      (s1_imm),
        .imm_bits (imm_bits),
        .imm_bad  (imm_bad)
    );

    always_comb begin
        logic [31:0] op_f, rd_f, f3_f, rs1_f, rs2_f, f7_f;
        op_f  = {25'd0, s1_opcode};
        rd_f  = 32'(s1_rd)     << RD_LSB;
        f3_f  = 32'(s1_funct3) << F3_LSB;
        rs1_f = 32'(s1_rs1)    << RS1_LSB;
        rs2_f = 32'(s1_rs2)    << RS2_LSB;
        f7_f  = 32'(s1_funct7) << F7_LSB;
        packed_word = '0;
        case (fmt_e'(s1_fmt))
            FMT_R:        packed_word = op_f | rd_f | f3_f | rs1_f | rs2_f | f7_f;
            FMT_I:        packed_word = op_f | rd_f | f3_f | rs1_f | imm_bits;
            FMT_S, FMT_B: packed_word = op_f | f3_f | rs1_f | rs2_f | imm_bits;
            FMT_U, FMT_J: packed_word = op_f | rd_f | imm_bits;
            default:      packed_word = '0;
        endcase
        packed_err = fmt_reserved(s1_fmt) || imm_bad;
    end

    // Request fields are pure data and only move on an accepted request.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_fmt    <= in_fmt;
            s1_opcode <= in_opcode;
            s1_rd     <= in_rd;
            s1_funct3 <= in_funct3;
            s1_rs1    <= in_rs1;
            s1_rs2    <= in_rs2;
            s1_funct7 <= in_funct7;
            s1_imm    <= in_imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q     <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            enc_count <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (s1_advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= packed_word;
                    out_err   <= packed_err;
                end
            end
            if (out_valid && out_ready) begin
                enc_count <= enc_count + COUNT_W'(1);
            end
        end
    end

endmodule
